// File: rtl/omsp_wdt_pkg.sv
// omsp_wdt_pkg
// Shared definitions for the openMSP430 watchdog:
//   - WDTCTL bit positions
//   - write password and read-back signature
//   - the mask applied to stored control bits
//   - mapping from WDTIS to the counter tap width
package omsp_wdt_pkg;

  localparam int WDTHOLD_B  = 7;
  localparam int WDTTMSEL_B = 4;
  localparam int WDTCNTCL_B = 3;
  localparam int WDTSSEL_B  = 2;

  localparam logic [7:0] WDT_PW      = 8'h5A;
  localparam logic [7:0] WDT_RD_PW   = 8'h69;
  // Bits 6:5 are unimplemented; bit 3 (counter clear) is an action, never stored.
  localparam logic [7:0] WDT_WR_MASK = 8'h97;

  // Number of low counter bits that must be all ones for an expiry.
  function automatic logic [3:0] wdt_tap_width(input logic [1:0] wdtis);
    logic [3:0] k;
    case (wdtis)
      2'b00:   k = 4'd15;
      2'b01:   k = 4'd13;
      2'b10:   k = 4'd9;
      default: k = 4'd6;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/omsp_wdt_counter.sv
// omsp_wdt_counter
// 16-bit watchdog count with a selectable expiry tap.
// Ports:
//   mclk    in   system clock
//   puc_n   in   synchronous active-low reset
//   tick    in   selected clock-source enable
//   hold    in   freeze the count (WDTHOLD)
//   clr     in   clear the count; wins over increment and masks expiry
//   k       in   tap width, 6..15
//   expire  out  this tick wraps the low k bits
module omsp_wdt_counter
  import omsp_wdt_pkg::*;
(
  input  logic       mclk,
  input  logic       puc_n,
  input  logic       tick,
  input  logic       hold,
  input  logic       clr,
  input  logic [3:0] k,
  output logic       expire
);

  logic [15:0] wdtcnt;
  logic [15:0] tap_mask;
  logic        inc;

  assign inc      = tick & ~hold;
  assign tap_mask = ~(16'hFFFF << k);
  assign expire   = inc & ~clr & ((wdtcnt & tap_mask) == tap_mask);

  always_ff @(posedge mclk) begin
    if (!puc_n) begin
      wdtcnt <= 16'h0000;
    end else if (clr) begin
      wdtcnt <= 16'h0000;
    end else if (inc) begin
      wdtcnt <= wdtcnt + 16'd1;
    end
  end

endmodule

// File: rtl/omsp_watchdog.sv
// omsp_watchdog
// openMSP430 watchdog timer with password-protected WDTCTL register.
// Optional build macro: WDT_PASSWORD_CHECK_EN (bad password or byte write
// to WDTCTL triggers wdt_reset instead of being silently dropped).
// Ports:
//   mclk, puc_n        clock, synchronous active-low reset
//   aclk_en, smclk_en  clock-source tick enables
//   per_addr/din/en/wen peripheral bus (word address, data, enable, byte enables)
//   wdtie              interval interrupt enable
//   wdt_irq_acc        interrupt acknowledge
//   per_dout           read data, zero when not addressed
//   wdt_reset          one-cycle reset request
//   wdt_irq            interval interrupt request
//   wdttmsel           1 = interval mode, 0 = watchdog mode
module omsp_watchdog
  import omsp_wdt_pkg::*;
#(
  parameter logic [8:0] WDTCTL = 9'h120
) (
  input  logic        mclk,
  input  logic        puc_n,
  input  logic        aclk_en,
  input  logic        smclk_en,
  input  logic [7:0]  per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_wen,
  input  logic        wdtie,
  input  logic        wdt_irq_acc,
  output logic [15:0] per_dout,
  output logic        wdt_reset,
  output logic        wdt_irq,
  output logic        wdttmsel
);

  logic [7:0] wdtctl;
  logic       reg_sel;
  logic       wr_word;
  logic       rd;
  logic       wr_valid;
  logic       violation;
  logic       tick;
  logic       clr;
  logic       expire;
  logic       wdtifg;

  assign reg_sel = per_en & (per_addr == WDTCTL[8:1]);
  assign wr_word = reg_sel & (per_wen == 2'b11);
  assign rd      = reg_sel & (per_wen == 2'b00);

`ifdef WDT_PASSWORD_CHECK_EN
  logic pw_ok;
  assign pw_ok     = (per_din[15:8] == WDT_PW);
  assign wr_valid  = wr_word & pw_ok;
  assign violation = (wr_word & ~pw_ok) |
                     (reg_sel & ((per_wen == 2'b01) | (per_wen == 2'b10)));
`else
  logic unused_pw;
  assign unused_pw = &{1'b0, per_din[15:8]};
  assign wr_valid  = wr_word;
  assign violation = 1'b0;
`endif

  always_ff @(posedge mclk) begin
    if (!puc_n) begin
      wdtctl <= 8'h00;
    end else if (wr_valid) begin
      wdtctl <= per_din[7:0] & WDT_WR_MASK;
    end
  end

  assign wdttmsel = wdtctl[WDTTMSEL_B];
  assign tick     = wdtctl[WDTSSEL_B] ? aclk_en : smclk_en;
  assign clr      = wr_valid & per_din[WDTCNTCL_B];

  omsp_wdt_counter u_counter (
    .mclk   (mclk),
    .puc_n  (puc_n),
    .tick   (tick),
    .hold   (wdtctl[WDTHOLD_B]),
    .clr    (clr),
    .k      (wdt_tap_width(wdtctl[1:0])),
    .expire (expire)
  );

  always_ff @(posedge mclk) begin
    if (!puc_n) begin
      wdt_reset <= 1'b0;
    end else begin
      wdt_reset <= (expire & ~wdttmsel) | violation;
    end
  end

  // A set in the same cycle as an acknowledge must not be lost.
  always_ff @(posedge mclk) begin
    if (!puc_n) begin
      wdtifg <= 1'b0;
    end else if (expire & wdttmsel) begin
      wdtifg <= 1'b1;
    end else if (wdt_irq_acc) begin
      wdtifg <= 1'b0;
    end
  end

  assign wdt_irq  = wdtifg & wdtie & wdttmsel;
  assign per_dout = rd ? {WDT_RD_PW, wdtctl[7:4], 1'b0, wdtctl[2:0]} : 16'h0000;

endmodule

// File: tb/tb_omsp_watchdog.sv
module tb_omsp_watchdog;

  logic        mclk = 1'b0;
  logic        puc_n;
  logic        aclk_en;
  logic        smclk_en;
  logic [7:0]  per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_wen;
  logic        wdtie;
  logic        wdt_irq_acc;
  logic [15:0] per_dout;
  logic        wdt_reset;
  logic        wdt_irq;
  logic        wdttmsel;

  int checks = 0;
  int passes = 0;

  omsp_watchdog dut (
    .mclk        (mclk),
    .puc_n       (puc_n),
    .aclk_en     (aclk_en),
    .smclk_en    (smclk_en),
    .per_addr    (per_addr),
    .per_din     (per_din),
    .per_en      (per_en),
    .per_wen     (per_wen),
    .wdtie       (wdtie),
    .wdt_irq_acc (wdt_irq_acc),
    .per_dout    (per_dout),
    .wdt_reset   (wdt_reset),
    .wdt_irq     (wdt_irq),
    .wdttmsel    (wdttmsel)
  );

  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic do_reset();
    puc_n = 1'b0; aclk_en = 1'b0; smclk_en = 1'b0;
    per_addr = 8'h00; per_din = 16'h0000; per_en = 1'b0; per_wen = 2'b00;
    wdtie = 1'b0; wdt_irq_acc = 1'b0;
    repeat (3) step();
    puc_n = 1'b1;
  endtask

  task automatic wr(input logic [15:0] data, input logic [1:0] wen);
    per_addr = 8'h90; per_din = data; per_en = 1'b1; per_wen = wen;
    step();
    per_en = 1'b0; per_wen = 2'b00; per_din = 16'h0000;
  endtask

  task automatic rd(output logic [15:0] data);
    per_addr = 8'h90; per_en = 1'b1; per_wen = 2'b00;
    #1 data = per_dout;
    per_en = 1'b0;
  endtask

  // Runs n SMCLK ticks; reports number of wdt_reset cycles and the first tick index with a pulse.
  task automatic run_smclk(input int n, output int pulses, output int first);
    pulses = 0; first = -1;
    smclk_en = 1'b1;
    for (int i = 1; i <= n; i++) begin
      step();
      if (wdt_reset) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    smclk_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    puc_n = 1'b0;
    per_en = 1'b0;
    step();
    checks++;
    if (per_dout !== 16'h0000 || wdt_reset !== 1'b0 || wdt_irq !== 1'b0 || wdttmsel !== 1'b0)
      $display("FAIL reset_outputs dout=%h rst=%b irq=%b tmsel=%b expected 0000/0/0/0",
               per_dout, wdt_reset, wdt_irq, wdttmsel);
    else passes++;
    rd(d);
    checks++;
    if (d !== 16'h6900) $display("FAIL reset_read got %h expected 6900", d);
    else passes++;
    per_addr = 8'h91; per_en = 1'b1; per_wen = 2'b00;
    #1;
    checks++;
    if (per_dout !== 16'h0000) $display("FAIL other_addr_read got %h expected 0000", per_dout);
    else passes++;
    per_en = 1'b0;
  endtask

  task automatic test_first_expiry();
    int pulses, first;
    do_reset();
    run_smclk(32770, pulses, first);
    checks++;
    if (first !== 32768) $display("FAIL first_expiry_tick got %0d expected 32768", first);
    else passes++;
    checks++;
    if (pulses !== 1) $display("FAIL expiry_pulse_width got %0d expected 1", pulses);
    else passes++;
  endtask

  task automatic aclk_ticks(input int n, output int rise, output int resets);
    rise = -1; resets = 0;
    for (int i = 1; i <= n; i++) begin
      aclk_en = 1'b1;
      step();
      aclk_en = 1'b0;
      if (wdt_irq && rise < 0) rise = i;
      if (wdt_reset) resets++;
      repeat (3) step();
    end
  endtask

  task automatic test_interval();
    int rise, resets;
    do_reset();
    wr(16'h5A1F, 2'b11);
    wdtie = 1'b1;
    checks++;
    if (wdttmsel !== 1'b1) $display("FAIL interval_tmsel got %b expected 1", wdttmsel);
    else passes++;
    aclk_ticks(64, rise, resets);
    checks++;
    if (rise !== 64 || resets !== 0)
      $display("FAIL interval_first_irq rise=%0d resets=%0d expected 64/0", rise, resets);
    else passes++;
    wdt_irq_acc = 1'b1;
    step();
    wdt_irq_acc = 1'b0;
    checks++;
    if (wdt_irq !== 1'b0) $display("FAIL interval_ack got %b expected 0", wdt_irq);
    else passes++;
    aclk_ticks(64, rise, resets);
    checks++;
    if (rise !== 64) $display("FAIL interval_second_irq rise=%0d expected 64", rise);
    else passes++;
  endtask

  task automatic test_kick();
    int pulses, first, total;
    do_reset();
    wr(16'h5A0B, 2'b11);
    total = 0;
    for (int j = 0; j < 25; j++) begin
      run_smclk(40, pulses, first);
      total += pulses;
      wr(16'h5A0B, 2'b11);
    end
    checks++;
    if (total !== 0) $display("FAIL kick_no_reset got %0d pulses expected 0", total);
    else passes++;
    run_smclk(66, pulses, first);
    checks++;
    if (first !== 64) $display("FAIL kick_unserviced_expiry got %0d expected 64", first);
    else passes++;
  endtask

  task automatic test_hold();
    int pulses, first;
    logic [15:0] d;
    do_reset();
    wr(16'h5A08, 2'b11);
    run_smclk(100, pulses, first);
    wr(16'h5A80, 2'b11);
    rd(d);
    checks++;
    if (d !== 16'h6980) $display("FAIL hold_read got %h expected 6980", d);
    else passes++;
    run_smclk(33000, pulses, first);
    checks++;
    if (pulses !== 0) $display("FAIL hold_no_expiry got %0d pulses expected 0", pulses);
    else passes++;
    checks++;
    if (dut.u_counter.wdtcnt !== 16'd100)
      $display("FAIL hold_frozen_count got %0d expected 100", dut.u_counter.wdtcnt);
    else passes++;
    // Release at /64 with count 100: next low-6-bit all-ones is 127, 28 ticks away.
    wr(16'h5A03, 2'b11);
    run_smclk(30, pulses, first);
    checks++;
    if (first !== 28) $display("FAIL tap_change_expiry got %0d expected 28", first);
    else passes++;
  endtask

  task automatic test_password();
    logic [15:0] d;
    do_reset();
    wr(16'h1280, 2'b11);
`ifdef WDT_PASSWORD_CHECK_EN
    checks++;
    if (wdt_reset !== 1'b1) $display("FAIL bad_pw_reset got %b expected 1", wdt_reset);
    else passes++;
    rd(d);
    checks++;
    if (d !== 16'h6900) $display("FAIL bad_pw_unchanged got %h expected 6900", d);
    else passes++;
    wr(16'h5A10, 2'b01);
    checks++;
    if (wdt_reset !== 1'b1) $display("FAIL byte_write_reset got %b expected 1", wdt_reset);
    else passes++;
`else
    checks++;
    if (wdt_reset !== 1'b0) $display("FAIL nopw_reset got %b expected 0", wdt_reset);
    else passes++;
    rd(d);
    checks++;
    if (d !== 16'h6980) $display("FAIL nopw_load got %h expected 6980", d);
    else passes++;
    wr(16'h5A10, 2'b01);
    checks++;
    if (wdt_reset !== 1'b0) $display("FAIL byte_write_reset got %b expected 0", wdt_reset);
    else passes++;
`endif
    rd(d);
    checks++;
    if (d !== 16'h6980 && d !== 16'h6900)
      $display("FAIL byte_write_ignored got %h expected unchanged", d);
    else if (d[4] !== 1'b0) $display("FAIL byte_write_ignored got %h expected bit4=0", d);
    else passes++;
    step();
    checks++;
    if (wdt_reset !== 1'b0) $display("FAIL reset_pulse_ends got %b expected 0", wdt_reset);
    else passes++;
  endtask

  task automatic test_collisions();
    int pulses, first;
    do_reset();
    wdtie = 1'b1;
    wr(16'h5A1B, 2'b11);
    run_smclk(63, pulses, first);
    checks++;
    if (wdt_irq !== 1'b0) $display("FAIL pre_collision_irq got %b expected 0", wdt_irq);
    else passes++;
    smclk_en = 1'b1;
    wr(16'h5A1B, 2'b11);
    smclk_en = 1'b0;
    checks++;
    if (wdt_irq !== 1'b0 || dut.u_counter.wdtcnt !== 16'd0)
      $display("FAIL clear_beats_expire irq=%b cnt=%0d expected 0/0", wdt_irq, dut.u_counter.wdtcnt);
    else passes++;
    run_smclk(63, pulses, first);
    smclk_en = 1'b1;
    wdt_irq_acc = 1'b1;
    step();
    smclk_en = 1'b0;
    wdt_irq_acc = 1'b0;
    checks++;
    if (wdt_irq !== 1'b1) $display("FAIL set_beats_ack got %b expected 1", wdt_irq);
    else passes++;
    wdt_irq_acc = 1'b1;
    step();
    wdt_irq_acc = 1'b0;
    checks++;
    if (wdt_irq !== 1'b0) $display("FAIL ack_alone got %b expected 0", wdt_irq);
    else passes++;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_first_expiry();
    test_interval();
    test_kick();
    test_hold();
    test_password();
    test_collisions();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
